btn_debounce: RTL and testbench

//  Conditions one raw push-button input for the LED press counter that sits directly downstream.

---
 rtl/debounce_pkg.sv | 7 +
 rtl/sync_ff.sv | 15 +
 rtl/btn_debounce.sv | 78 +++++++
 tb/tb_btn_debounce.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/debounce_pkg.sv
// debounce_pkg: shared state encoding and counter sizing for the button debouncer
package debounce_pkg;
  typedef enum logic [1:0] {S_IDLE, S_PRESS_WAIT, S_PRESSED, S_RELEASE_WAIT} db_state_t;
  function automatic int cnt_width(input int stable_cycles);
    return $clog2(stable_cycles + 1);
  endfunction
endpackage

// File: rtl/sync_ff.sv
// sync_ff: multi-flop synchroniser for one asynchronous input pin
module sync_ff #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic [STAGES-1:0] chain;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) chain <= '0;
    else chain <= {chain[STAGES-2:0], d};
  assign q = chain[STAGES-1];
endmodule

// File: rtl/btn_debounce.sv
// btn_debounce: synchronise and debounce one push-button, emit level plus press/release strobes
module btn_debounce
  import debounce_pkg::*;
#(
  parameter int SYNC_STAGES   = 2,
  parameter int STABLE_CYCLES = 100
) (
  input  logic sysclk,
  input  logic reset_btn_n,
  input  logic btn,
  output logic btn_level,
  output logic press_pulse,
  output logic release_pulse
);
  localparam int CW = cnt_width(STABLE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(STABLE_CYCLES - 1);
  logic btn_sync;
  db_state_t state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic level_n, press_n, release_n;
  sync_ff #(.STAGES(SYNC_STAGES)) u_sync (
    .clk(sysclk),
    .rst_n(reset_btn_n),
    .d(btn),
    .q(btn_sync)
  );
  always_ff @(posedge sysclk or negedge reset_btn_n)
    if (!reset_btn_n) begin
      state         <= S_IDLE;
      cnt           <= '0;
      btn_level     <= 1'b0;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
    end else begin
      state         <= state_n;
      cnt           <= cnt_n;
      btn_level     <= level_n;
      press_pulse   <= press_n;
      release_pulse <= release_n;
    end
  // A single disagreeing sample drops back to the settled state, so the window always restarts from 1.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    level_n   = btn_level;
    press_n   = 1'b0;
    release_n = 1'b0;
    case (state)
      S_IDLE: if (btn_sync) begin
        state_n = S_PRESS_WAIT;
        cnt_n   = CW'(1);
      end
      S_PRESS_WAIT:
        if (!btn_sync) state_n = S_IDLE;
        else if (cnt == LAST) begin
          state_n = S_PRESSED;
          level_n = 1'b1;
          press_n = 1'b1;
        end else cnt_n = cnt + 1'b1;
      S_PRESSED: if (!btn_sync) begin
        state_n = S_RELEASE_WAIT;
        cnt_n   = CW'(1);
      end
      S_RELEASE_WAIT:
        if (btn_sync) state_n = S_PRESSED;
        else if (cnt == LAST) begin
          state_n   = S_IDLE;
          level_n   = 1'b0;
          release_n = 1'b1;
        end else cnt_n = cnt + 1'b1;
      default: begin
        state_n = S_IDLE;
        cnt_n   = '0;
        level_n = 1'b0;
      end
    endcase
  end
endmodule

// File: tb/tb_btn_debounce.sv
// tb_btn_debounce: scoreboard bench for btn_debounce (short-window instance a, default instance b)
module tb_btn_debounce;
  typedef struct packed {
    logic rel;
    int   at;
  } ev_t;
  logic clk = 1'b0;
  always #10 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int tests = 0;
  int failed = 0;
  logic rst_a, btn_a, level_a, press_a, release_a;
  logic rst_b, btn_b, level_b, press_b, release_b;
  ev_t qa[$];
  int qb[$];
  logic [3:0] cnt4 = 4'd0;
  int pb = 0;
  int rb = 0;
  btn_debounce #(.SYNC_STAGES(2), .STABLE_CYCLES(8)) dut_a (
    .sysclk(clk), .reset_btn_n(rst_a), .btn(btn_a),
    .btn_level(level_a), .press_pulse(press_a), .release_pulse(release_a)
  );
  btn_debounce dut_b (
    .sysclk(clk), .reset_btn_n(rst_b), .btn(btn_b),
    .btn_level(level_b), .press_pulse(press_b), .release_pulse(release_b)
  );
  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  // Edge 1 is the posedge right after this negedge, so the strobe lands 10 cycles on.
  task automatic expect_a(input logic rel);
    qa.push_back(ev_t'{rel: rel, at: cyc + 10});
  endtask
  ev_t e;
  always @(negedge clk) begin
    if (press_a || release_a) begin
      check("no_overlap_a", press_a & release_a, 0);
      if (qa.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_strobe_a: press=%0b release=%0b, expected none (cycle %0d)", press_a, release_a, cyc);
      end else begin
        e = qa.pop_front();
        check("strobe_a_kind", release_a, e.rel);
        check("strobe_a_cycle", cyc, e.at);
      end
    end
    if (press_b) begin
      check("no_overlap_b", release_b, 0);
      cnt4 = cnt4 + 4'd1;
      pb++;
      if (qb.size() == 0) begin
        tests++;
        failed++;
        $display("FAIL unexpected_press_b: count %0d, expected no press (cycle %0d)", cnt4, cyc);
      end else check("press_count_b", cnt4, qb.pop_front());
    end
    if (release_b) rb++;
  end
  int bounce[9] = '{3, 7, 7, 15, 7, 27, 7, 15, 7};
  initial begin
    rst_a = 1'b0; btn_a = 1'b1;
    rst_b = 1'b0; btn_b = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick(1);
      check("reset_outputs_a", {level_a, press_a, release_a}, 0);
    end
    rst_a = 1'b1;
    expect_a(1'b0);
    tick(15);
    check("level_after_reset_press", level_a, 1);
    btn_a = 1'b0;
    expect_a(1'b1);
    tick(15);
    check("level_after_release", level_a, 0);
    btn_a = 1'b1;
    tick(7);
    btn_a = 1'b0;
    tick(15);
    check("level_short_pulse", level_a, 0);
    btn_a = 1'b1;
    expect_a(1'b0);
    tick(15);
    check("level_full_window", level_a, 1);
    btn_a = 1'b0;
    tick(3);
    btn_a = 1'b1;
    tick(15);
    check("level_short_release", level_a, 1);
    btn_a = 1'b0;
    expect_a(1'b1);
    tick(15);
    check("level_released", level_a, 0);
    btn_a = 1'b1;
    tick(5);
    rst_a = 1'b0;
    tick(3);
    rst_a = 1'b1;
    expect_a(1'b0);
    tick(15);
    check("level_after_midwindow_reset", level_a, 1);
    rst_a = 1'b0;
    #1;
    check("reset_clears_level", level_a, 0);
    btn_a = 1'b0;
    tick(3);
    rst_a = 1'b1;
    tick(15);
    check("level_idle_after_reset", level_a, 0);
    btn_a = 1'b1;
    expect_a(1'b0);
    tick(40);
    check("level_long_press", level_a, 1);
    btn_a = 1'b0;
    expect_a(1'b1);
    tick(40);
    check("level_long_release", level_a, 0);
    tick(15);
    rst_b = 1'b1;
    tick(5);
    for (int i = 0; i < 16; i++) begin
      qb.push_back((i + 1) % 16);
      btn_b = 1'b1;
      foreach (bounce[j]) begin
        #(bounce[j]);
        btn_b = ~btn_b;
      end
      btn_b = 1'b1;
      #6000;
      check("level_b_held", level_b, 1);
      btn_b = 1'b0;
      #3000;
      check("level_b_released", level_b, 0);
    end
    tick(20);
    check("pending_a", qa.size(), 0);
    check("pending_b", qb.size(), 0);
    check("presses_b", pb, 16);
    check("releases_b", rb, 16);
    check("cnt4_wrapped", cnt4, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
